// File: rtl/debug_loader_pkg.sv
// Shared types and helpers for the program loader / run controller.
// State encoding doubles as the debug readout value.
package debug_loader_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;

  function automatic int bytes_per_word(input int nb_data,
                                        input int nb_byte);
    return nb_data / nb_byte;
  endfunction

endpackage

// File: rtl/step_edge_sync.sv
// Synchronizes the host step request and emits one pulse per rising edge.
// The pulse is valid the cycle after the second sync flop sees the edge.
module step_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_step,
  output logic o_pulse
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= i_step;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign o_pulse = s2 & ~s3;

endmodule

// File: rtl/debug_loader.sv
// Loads program words from a byte stream, then runs, drains and
// freezes the MIPS core while counting its enabled cycles.
module debug_loader
  import debug_loader_pkg::*;
#(
  parameter int NB_DATA           = 32,
  parameter int NB_BYTE           = 8,
  parameter int RAM_DEPTH_PROGRAM = 32,
  parameter int NB_PADDR          = $clog2(RAM_DEPTH_PROGRAM),
  parameter logic [NB_DATA-1:0] HALT_WORD = {NB_DATA{1'b1}},
  parameter int DRAIN_CYCLES      = 4,
  parameter int NB_CYCLE          = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NB_BYTE-1:0]  i_rx_data,
  input  logic                i_rx_valid,
  input  logic                i_step_mode,
  input  logic                i_step,
  input  logic                i_reload,
  input  logic [NB_DATA-1:0]  i_fetch_word,
  output logic                o_prog_we,
  output logic [NB_PADDR-1:0] o_prog_addr,
  output logic [NB_DATA-1:0]  o_prog_data,
  output logic                o_cpu_rst,
  output logic                o_cpu_enable,
  output logic [NB_CYCLE-1:0] o_cycle_count,
  output logic                o_halted,
  output logic                o_load_overflow,
  output logic [1:0]          o_state
);

  localparam int BPW      = bytes_per_word(NB_DATA, NB_BYTE);
  localparam int NB_BIDX  = $clog2(BPW + 1);
  localparam int NB_DRAIN = $clog2(DRAIN_CYCLES + 1);

  localparam logic [NB_BIDX-1:0]  BIDX_LAST  = NB_BIDX'(BPW - 1);
  localparam logic [NB_DRAIN-1:0] DRAIN_LAST = NB_DRAIN'(DRAIN_CYCLES - 1);
  localparam logic [NB_PADDR-1:0] ADDR_LAST  =
    NB_PADDR'(RAM_DEPTH_PROGRAM - 1);

  state_t              state;
  logic [NB_DATA-1:0]  word;
  logic [NB_DATA-1:0]  assembled;
  logic [NB_BIDX-1:0]  byte_idx;
  logic [NB_PADDR-1:0] addr;
  logic [NB_DRAIN-1:0] drain_cnt;
  logic                step_mode;
  logic                step_pulse;

  step_edge_sync u_step_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_step  (i_step),
    .o_pulse (step_pulse)
  );

  // First byte ends up in the MSB after BPW shifts.
  assign assembled = {word[NB_DATA-NB_BYTE-1:0], i_rx_data};
  assign o_state   = state;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state           <= ST_LOAD;
      word            <= '0;
      byte_idx        <= '0;
      addr            <= '0;
      drain_cnt       <= '0;
      step_mode       <= 1'b0;
      o_prog_we       <= 1'b0;
      o_prog_addr     <= '0;
      o_prog_data     <= '0;
      o_cpu_rst       <= 1'b0;
      o_cpu_enable    <= 1'b0;
      o_cycle_count   <= '0;
      o_halted        <= 1'b0;
      o_load_overflow <= 1'b0;
    end else begin
      o_prog_we <= 1'b0;
      unique case (state)
        ST_LOAD: begin
          o_cpu_rst    <= 1'b0;
          o_cpu_enable <= 1'b0;
          if (i_rx_valid) begin
            word <= assembled;
            if (byte_idx == BIDX_LAST) begin
              byte_idx    <= '0;
              o_prog_we   <= 1'b1;
              o_prog_addr <= addr;
              o_prog_data <= assembled;
              if (addr != ADDR_LAST) addr <= addr + 1'b1;
              if (assembled == HALT_WORD) begin
                state     <= ST_EXEC;
                step_mode <= i_step_mode;
              end else if (addr == ADDR_LAST) begin
                state           <= ST_EXEC;
                step_mode       <= i_step_mode;
                o_load_overflow <= 1'b1;
              end
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        ST_EXEC, ST_DRAIN: begin
          o_cpu_rst    <= 1'b1;
          o_cpu_enable <= step_mode ? step_pulse : 1'b1;
          if (o_cpu_enable) begin
            if (o_cycle_count != '1)
              o_cycle_count <= o_cycle_count + 1'b1;
            if (state == ST_EXEC) begin
              if (i_fetch_word == HALT_WORD) state <= ST_DRAIN;
            end else if (drain_cnt == DRAIN_LAST) begin
              state        <= ST_DONE;
              o_halted     <= 1'b1;
              o_cpu_enable <= 1'b0;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          o_cpu_enable <= 1'b0;
          o_halted     <= 1'b1;
          if (i_reload) begin
            state           <= ST_LOAD;
            word            <= '0;
            byte_idx        <= '0;
            addr            <= '0;
            drain_cnt       <= '0;
            o_cycle_count   <= '0;
            o_halted        <= 1'b0;
            o_load_overflow <= 1'b0;
            o_cpu_rst       <= 1'b0;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule
